// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS control pipeline:
//   - forwarding select encodings (FWD_RF / FWD_EXMEM / FWD_MEMWB)
//   - ALU operation class encodings
//   - register-address width REG_AW
//   - packed stage-register bundles for ID/EX, EX/MEM and MEM/WB
//   - reg_match(): "non-zero destination matches one of two sources"
// No ports (package).
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int REG_AW = 5;

    // EX operand source selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // ALU operation classes produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores address calc
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R-type, decode funct field
    localparam logic [1:0] ALUOP_IMM   = 2'b11;  // immediate arithmetic/logic

    // ID/EX contents: full control bundle plus the source fields needed for
    // forwarding and the destination resolved at ID.
    typedef struct packed {
        logic              reg_write;
        logic              alu_src;
        logic              reg_dst;
        logic              mem_write;
        logic              mem_read;
        logic              mem_to_reg;
        logic [1:0]        alu_op;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dst;
    } ctrl_bundle_t;

    // EX/MEM contents: only what MEM and WB still consume.
    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic              mem_to_reg;
        logic [REG_AW-1:0] dst;
    } mem_bundle_t;

    // MEM/WB contents.
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] dst;
    } wb_bundle_t;

    // $0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [REG_AW-1:0] dst,
                                       input logic [REG_AW-1:0] src_a,
                                       input logic [REG_AW-1:0] src_b);
        return (dst != '0) && ((dst == src_a) || (dst == src_b));
    endfunction

endpackage

// File: rtl/ctrl_hazard.sv
// ----------------------------------------------------------------------------
// ctrl_hazard
// Combinational hazard detection and EX operand forwarding selects.
//
// Ports:
//   rst, mem_stall              in   reset (masks stalls), cache-miss freeze
//   id_rs, id_rt                in   source fields of the instruction in ID
//   ex_RegWrite, ex_MemRead     in   EX-stage writer info
//   ex_dst, ex_rs, ex_rt        in   EX-stage destination and sources
//   mem_RegWrite, mem_dst       in   MEM-stage writer info
//   wb_RegWrite, wb_dst         in   WB-stage writer info
//   hz                          out  insert a bubble into ID/EX
//   stall_pc, stall_ifid        out  hold PC and IF/ID
//   fwdA, fwdB                  out  EX operand selects (mips_pkg FWD_*)
//
// Build option CTRL_PIPE_FWD_EN:
//   defined   - forwarding enabled; only load-use in EX stalls.
//   undefined - no forwarding; any RAW against an EX or MEM writer stalls
//               until that writer reaches WB (regfile is write-first).
// ----------------------------------------------------------------------------
module ctrl_hazard
    import mips_pkg::*;
(
    input  logic              rst,
    input  logic              mem_stall,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_RegWrite,
    input  logic              ex_MemRead,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_RegWrite,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              wb_RegWrite,
    input  logic [REG_AW-1:0] wb_dst,
    output logic              hz,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB
);

`ifdef CTRL_PIPE_FWD_EN
    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic              m_we,
                                           input logic [REG_AW-1:0] m_dst,
                                           input logic              w_we,
                                           input logic [REG_AW-1:0] w_dst,
                                           input logic [REG_AW-1:0] src);
        if (m_we && m_dst != '0 && m_dst == src) begin
            return FWD_EXMEM;
        end
        if (w_we && w_dst != '0 && w_dst == src) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    // Only a load in EX cannot be covered: its data exists after MEM.
    assign hz   = ex_MemRead & reg_match(ex_dst, id_rs, id_rt);
    assign fwdA = fwd_sel(mem_RegWrite, mem_dst, wb_RegWrite, wb_dst, ex_rs);
    assign fwdB = fwd_sel(mem_RegWrite, mem_dst, wb_RegWrite, wb_dst, ex_rt);

    // EX write-enable only matters to the no-forwarding hazard term.
    logic unused_nofwd_only;
    assign unused_nofwd_only = ex_RegWrite;
`else
    // Without forwarding every in-flight writer ahead of WB blocks ID.
    // A WB-stage writer is fine because the regfile writes before reading.
    assign hz = ((ex_RegWrite | ex_MemRead) & reg_match(ex_dst, id_rs, id_rt))
              | (mem_RegWrite & reg_match(mem_dst, id_rs, id_rt));
    assign fwdA = FWD_RF;
    assign fwdB = FWD_RF;

    // EX sources and the WB writer only feed the forwarding muxes.
    logic unused_fwd_only;
    assign unused_fwd_only = ^{ex_rs, ex_rt, wb_RegWrite, wb_dst};
`endif

    // A cache miss freezes the front end too; during reset nothing is held.
    assign stall_pc   = ~rst & (mem_stall | hz);
    assign stall_ifid = ~rst & (mem_stall | hz);

endmodule

// File: rtl/ctrl_pipe.sv
// ----------------------------------------------------------------------------
// ctrl_pipe
// Control-path stage registers of the 5-stage MIPS pipeline. Carries the
// decoded control bundle and destination register from ID through EX, MEM
// and WB, inserts load-use bubbles and honours a global cache stall.
// Hazard and forwarding decisions live in ctrl_hazard.
//
// Parameters:
//   REG_AW   register-address width (must equal mips_pkg::REG_AW)
//   RA_IDX   destination register used for jal/jalr (id_raWrite=1)
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_stall                        cache miss; freezes every stage register
//   id_RegWrite .. id_raWrite        decoded control from ID
//   id_ALUOp                         decoded ALU op class
//   id_rs, id_rt, id_rd              ID register fields
//   ex_ALUSrc, ex_RegDst, ex_ALUOp   EX-stage control
//   mem_MemWrite, mem_MemRead        MEM-stage control
//   wb_RegWrite, wb_MemtoReg, wb_dst WB-stage control and write address
//   stall_pc, stall_ifid             hold PC and IF/ID
//   fwdA, fwdB                       EX operand selects
//
// Build option CTRL_PIPE_FWD_EN enables forwarding (see ctrl_hazard).
// ----------------------------------------------------------------------------
module ctrl_pipe #(
    parameter int REG_AW = 5,
    parameter int RA_IDX = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_stall,
    input  logic              id_RegWrite,
    input  logic              id_ALUSrc,
    input  logic              id_RegDst,
    input  logic              id_MemWrite,
    input  logic              id_MemRead,
    input  logic              id_MemtoReg,
    input  logic              id_raWrite,
    input  logic [1:0]        id_ALUOp,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              ex_ALUSrc,
    output logic              ex_RegDst,
    output logic [1:0]        ex_ALUOp,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [REG_AW-1:0] wb_dst,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB
);
    import mips_pkg::*;

    localparam logic [REG_AW-1:0] RA_DST = REG_AW'(RA_IDX);

    ctrl_bundle_t id_b;
    ctrl_bundle_t ex_q;
    mem_bundle_t  mem_q;
    wb_bundle_t   wb_q;
    logic         hz;

    // ---- ID: assemble bundle, resolve destination early ----
    always_comb begin
        id_b            = '0;
        id_b.reg_write  = id_RegWrite;
        id_b.alu_src    = id_ALUSrc;
        id_b.reg_dst    = id_RegDst;
        id_b.mem_write  = id_MemWrite;
        id_b.mem_read   = id_MemRead;
        id_b.mem_to_reg = id_MemtoReg;
        id_b.alu_op     = id_ALUOp;
        id_b.rs         = id_rs;
        id_b.rt         = id_rt;
        id_b.dst        = id_raWrite ? RA_DST : (id_RegDst ? id_rd : id_rt);
    end

    // ---- ID/EX, EX/MEM, MEM/WB stage registers ----
    // mem_stall outranks hz: while frozen the ID/EX register keeps its
    // contents rather than taking a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_stall) begin
            ex_q             <= hz ? '0 : id_b;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_q.dst        <= ex_q.dst;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_q.mem_to_reg  <= mem_q.mem_to_reg;
            wb_q.dst         <= mem_q.dst;
        end
    end

    ctrl_hazard u_hazard (
        .rst          (rst),
        .mem_stall    (mem_stall),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_RegWrite  (ex_q.reg_write),
        .ex_MemRead   (ex_q.mem_read),
        .ex_dst       (ex_q.dst),
        .ex_rs        (ex_q.rs),
        .ex_rt        (ex_q.rt),
        .mem_RegWrite (mem_q.reg_write),
        .mem_dst      (mem_q.dst),
        .wb_RegWrite  (wb_q.reg_write),
        .wb_dst       (wb_q.dst),
        .hz           (hz),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .fwdA         (fwdA),
        .fwdB         (fwdB)
    );

    assign ex_ALUSrc    = ex_q.alu_src;
    assign ex_RegDst    = ex_q.reg_dst;
    assign ex_ALUOp     = ex_q.alu_op;
    assign mem_MemWrite = mem_q.mem_write;
    assign mem_MemRead  = mem_q.mem_read;
    assign wb_RegWrite  = wb_q.reg_write;
    assign wb_MemtoReg  = wb_q.mem_to_reg;
    assign wb_dst       = wb_q.dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// ----------------------------------------------------------------------------
// tb_ctrl_pipe
// Directed bench for ctrl_pipe. Expected values adapt to CTRL_PIPE_FWD_EN.
// ----------------------------------------------------------------------------
module tb_ctrl_pipe;
`ifdef CTRL_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, mem_stall;
    logic       id_RegWrite, id_ALUSrc, id_RegDst, id_MemWrite, id_MemRead, id_MemtoReg, id_raWrite;
    logic [1:0] id_ALUOp;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_ALUSrc, ex_RegDst, mem_MemWrite, mem_MemRead, wb_RegWrite, wb_MemtoReg;
    logic [1:0] ex_ALUOp, fwdA, fwdB;
    logic [4:0] wb_dst;
    logic       stall_pc, stall_ifid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_AW(5), .RA_IDX(31)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall),
        .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
        .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
        .id_raWrite(id_raWrite), .id_ALUOp(id_ALUOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_ALUOp(ex_ALUOp),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .fwdA(fwdA), .fwdB(fwdB)
    );

    typedef struct packed {
        logic       rw, alusrc, regdst, memw, memr, m2r, ra;
        logic [1:0] aluop;
        logic [4:0] rs, rt, rd;
    } instr_t;

    localparam instr_t NOP = '0;

    // Loads get ALUSrc/MemtoReg and ALUOp=add; others are R-type style.
    function automatic instr_t ins(input logic rw, input logic memr, input logic regdst,
                                   input logic ra, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] rd);
        instr_t x;
        x        = '0;
        x.rw     = rw;
        x.memr   = memr;
        x.alusrc = memr;
        x.m2r    = memr;
        x.regdst = regdst;
        x.ra     = ra;
        x.aluop  = memr ? 2'b00 : 2'b10;
        x.rs     = rs;
        x.rt     = rt;
        x.rd     = rd;
        return x;
    endfunction

    function automatic logic [12:0] pipe_state();
        return {ex_ALUSrc, ex_RegDst, ex_ALUOp, mem_MemWrite, mem_MemRead,
                wb_RegWrite, wb_MemtoReg, wb_dst};
    endfunction

    function automatic logic [18:0] all_out();
        return {pipe_state(), stall_pc, stall_ifid, fwdA, fwdB};
    endfunction

    task automatic drive(input instr_t x);
        id_RegWrite = x.rw;   id_ALUSrc  = x.alusrc; id_RegDst  = x.regdst;
        id_MemWrite = x.memw; id_MemRead = x.memr;   id_MemtoReg = x.m2r;
        id_raWrite  = x.ra;   id_ALUOp   = x.aluop;
        id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    endtask

    // Present x at ID and clock until it is accepted into EX. Returns the
    // number of stalled cycles seen (bounded; 99 on timeout).
    task automatic issue(input instr_t x, output int st);
        st = 0;
        drive(x);
        #1;
        while (stall_pc && st < 20) begin
            st++;
            @(posedge clk); #1;
        end
        if (stall_pc) st = 99;
        @(posedge clk); #1;
    endtask

    task automatic flush();
        int st;
        repeat (4) issue(NOP, st);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_stall = 1'b1;
        id_RegWrite = 1; id_ALUSrc = 1; id_RegDst = 1; id_MemWrite = 1;
        id_MemRead = 1; id_MemtoReg = 1; id_raWrite = 1; id_ALUOp = 2'b11;
        id_rs = 5'h1f; id_rt = 5'h1f; id_rd = 5'h1f;
        @(posedge clk); #1;
        checks++; if (all_out() !== 19'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out()); end
        checks++; if ({fwdA, fwdB} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b want 0000", {fwdA, fwdB}); end
        rst = 1'b0; mem_stall = 1'b0;
        drive(NOP);
        @(posedge clk); #1;
        checks++; if (all_out() !== 19'h0) begin errors++; $display("FAIL reset_empty: got %h want 0", all_out()); end
    endtask

    task automatic test_plain_flow();
        int st;
        flush();
        issue(ins(1, 0, 1, 0, 5'd2, 5'd3, 5'd8), st);
        checks++; if (st !== 0) begin errors++; $display("FAIL plain_stall: got %0d want 0", st); end
        checks++; if ({ex_RegDst, ex_ALUOp, ex_ALUSrc} !== 4'b1100) begin errors++; $display("FAIL plain_ex: got %b want 1100", {ex_RegDst, ex_ALUOp, ex_ALUSrc}); end
        issue(NOP, st);
        checks++; if (wb_RegWrite !== 1'b0) begin errors++; $display("FAIL plain_early_wb: got %b want 0", wb_RegWrite); end
        issue(NOP, st);
        checks++; if ({wb_RegWrite, wb_dst} !== {1'b1, 5'd8}) begin errors++; $display("FAIL plain_wb: got %b want 101000", {wb_RegWrite, wb_dst}); end
    endtask

    task automatic test_jal();
        int st;
        flush();
        issue(ins(1, 0, 1, 1, 5'd0, 5'd6, 5'd5), st);
        issue(NOP, st);
        issue(NOP, st);
        checks++; if ({wb_RegWrite, wb_dst} !== {1'b1, 5'd31}) begin errors++; $display("FAIL jal_wb: got %b want 111111", {wb_RegWrite, wb_dst}); end
    endtask

    task automatic test_load_use();
        int st;
        flush();
        issue(ins(1, 1, 0, 0, 5'd4, 5'd9, 5'd0), st);
        drive(ins(1, 0, 1, 0, 5'd9, 5'd7, 5'd10));
        #1;
        checks++; if ({stall_pc, stall_ifid} !== 2'b11) begin errors++; $display("FAIL lu_stall: got %b want 11", {stall_pc, stall_ifid}); end
        @(posedge clk); #1;
        checks++; if ({ex_ALUSrc, ex_RegDst, ex_ALUOp} !== 4'b0000) begin errors++; $display("FAIL lu_bubble: got %b want 0000", {ex_ALUSrc, ex_RegDst, ex_ALUOp}); end
        checks++; if (mem_MemRead !== 1'b1) begin errors++; $display("FAIL lu_mem_read: got %b want 1", mem_MemRead); end
        issue(ins(1, 0, 1, 0, 5'd9, 5'd7, 5'd10), st);
        checks++; if (st !== (FWD ? 0 : 1)) begin errors++; $display("FAIL lu_extra_stall: got %0d want %0d", st, FWD ? 0 : 1); end
        checks++; if (ex_RegDst !== 1'b1) begin errors++; $display("FAIL lu_add_in_ex: got %b want 1", ex_RegDst); end
        checks++; if (fwdA !== (FWD ? 2'b01 : 2'b00)) begin errors++; $display("FAIL lu_fwdA: got %b want %b", fwdA, FWD ? 2'b01 : 2'b00); end
        checks++; if (fwdB !== 2'b00) begin errors++; $display("FAIL lu_fwdB: got %b want 00", fwdB); end
        checks++; if (wb_MemtoReg !== (FWD ? 1'b1 : 1'b0)) begin errors++; $display("FAIL lu_wb_m2r: got %b want %b", wb_MemtoReg, FWD); end
    endtask

    task automatic test_back_to_back();
        int st;
        flush();
        issue(ins(1, 1, 0, 0, 5'd4, 5'd9, 5'd0), st);
        issue(ins(1, 0, 1, 0, 5'd9, 5'd0, 5'd10), st);
        checks++; if (st !== (FWD ? 1 : 2)) begin errors++; $display("FAIL b2b_add_stall: got %0d want %0d", st, FWD ? 1 : 2); end
        checks++; if (fwdA !== (FWD ? 2'b01 : 2'b00)) begin errors++; $display("FAIL b2b_add_fwdA: got %b want %b", fwdA, FWD ? 2'b01 : 2'b00); end
        issue(ins(1, 0, 1, 0, 5'd10, 5'd9, 5'd11), st);
        checks++; if (st !== (FWD ? 0 : 2)) begin errors++; $display("FAIL b2b_sub_stall: got %0d want %0d", st, FWD ? 0 : 2); end
        checks++; if ({fwdA, fwdB} !== (FWD ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL b2b_sub_fwd: got %b want %b", {fwdA, fwdB}, FWD ? 4'b1000 : 4'b0000); end
    endtask

    task automatic test_forward_priority();
        int st;
        flush();
        issue(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd10), st);
        issue(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd10), st);
        issue(ins(1, 0, 1, 0, 5'd10, 5'd3, 5'd12), st);
        checks++; if (st !== (FWD ? 0 : 2)) begin errors++; $display("FAIL prio_stall: got %0d want %0d", st, FWD ? 0 : 2); end
        checks++; if ({fwdA, fwdB} !== (FWD ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL prio_fwd: got %b want %b", {fwdA, fwdB}, FWD ? 4'b1000 : 4'b0000); end
        flush();
        issue(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd0), st);
        issue(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd0), st);
        issue(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd12), st);
        checks++; if (st !== 0) begin errors++; $display("FAIL zero_stall: got %0d want 0", st); end
        checks++; if ({fwdA, fwdB} !== 4'b0000) begin errors++; $display("FAIL zero_fwd: got %b want 0000", {fwdA, fwdB}); end
        flush();
        issue(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd11), st);
        issue(NOP, st);
        issue(ins(1, 0, 1, 0, 5'd0, 5'd11, 5'd13), st);
        checks++; if (st !== (FWD ? 0 : 1)) begin errors++; $display("FAIL memwb_stall: got %0d want %0d", st, FWD ? 0 : 1); end
        checks++; if ({fwdA, fwdB} !== (FWD ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL memwb_fwd: got %b want %b", {fwdA, fwdB}, FWD ? 4'b0001 : 4'b0000); end
    endtask

    task automatic test_raw_no_load();
        int st;
        flush();
        issue(ins(1, 0, 1, 0, 5'd1, 5'd2, 5'd12), st);
        issue(ins(1, 0, 1, 0, 5'd12, 5'd12, 5'd14), st);
        checks++; if (st !== (FWD ? 0 : 2)) begin errors++; $display("FAIL raw_stall: got %0d want %0d", st, FWD ? 0 : 2); end
        checks++; if ({fwdA, fwdB} !== (FWD ? 4'b1010 : 4'b0000)) begin errors++; $display("FAIL raw_fwd: got %b want %b", {fwdA, fwdB}, FWD ? 4'b1010 : 4'b0000); end
    endtask

    task automatic test_mem_stall();
        int st;
        instr_t sw;
        logic [12:0] snap;
        flush();
        sw      = ins(0, 0, 0, 0, 5'd2, 5'd5, 5'd0);
        sw.memw = 1'b1;
        issue(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd1), st);
        issue(sw, st);
        drive(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd3));
        mem_stall = 1'b1;
        #1;
        snap = pipe_state();
        for (int i = 0; i < 3; i++) begin
            checks++; if ({stall_pc, stall_ifid} !== 2'b11) begin errors++; $display("FAIL ms_stall[%0d]: got %b want 11", i, {stall_pc, stall_ifid}); end
            @(posedge clk); #1;
            checks++; if (pipe_state() !== snap) begin errors++; $display("FAIL ms_hold[%0d]: got %h want %h", i, pipe_state(), snap); end
        end
        mem_stall = 1'b0;
        issue(ins(1, 0, 1, 0, 5'd0, 5'd0, 5'd3), st);
        checks++; if ({wb_RegWrite, wb_dst, mem_MemWrite} !== {1'b1, 5'd1, 1'b1}) begin errors++; $display("FAIL ms_wb0: got %b want 1000011", {wb_RegWrite, wb_dst, mem_MemWrite}); end
        issue(NOP, st);
        checks++; if ({wb_RegWrite, wb_dst} !== {1'b0, 5'd5}) begin errors++; $display("FAIL ms_wb1: got %b want 000101", {wb_RegWrite, wb_dst}); end
        issue(NOP, st);
        checks++; if ({wb_RegWrite, wb_dst} !== {1'b1, 5'd3}) begin errors++; $display("FAIL ms_wb2: got %b want 100011", {wb_RegWrite, wb_dst}); end
        issue(NOP, st);
        checks++; if ({wb_RegWrite, wb_dst} !== 6'b0) begin errors++; $display("FAIL ms_wb3: got %b want 000000", {wb_RegWrite, wb_dst}); end
        // cache stall outranks a load-use hazard: the load stays in EX
        flush();
        issue(ins(1, 1, 0, 0, 5'd4, 5'd9, 5'd0), st);
        drive(ins(1, 0, 1, 0, 5'd9, 5'd7, 5'd10));
        mem_stall = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ex_ALUSrc, ex_RegDst, stall_pc} !== 3'b101) begin errors++; $display("FAIL ms_prio: got %b want 101", {ex_ALUSrc, ex_RegDst, stall_pc}); end
        mem_stall = 1'b0;
    endtask

    task automatic test_reset_in_stall();
        int st;
        flush();
        issue(ins(1, 1, 0, 0, 5'd4, 5'd9, 5'd0), st);
        drive(ins(1, 0, 1, 0, 5'd9, 5'd7, 5'd10));
        mem_stall = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_stall = 1'b0;
        drive(NOP);
        #1;
        checks++; if (all_out() !== 19'h0) begin errors++; $display("FAIL rst_in_stall: got %h want 0", all_out()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_plain_flow();
        test_jal();
        test_load_use();
        test_back_to_back();
        test_forward_priority();
        test_raw_no_load();
        test_mem_stall();
        test_reset_in_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
